// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode constants, decode FSM state,
// immediate format selector and small opcode classification helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_CHECK,
    S_READ,
    S_ISSUE
  } decode_state_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                                       return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_BRANCH, OPC_STORE, OPC_OP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: purely combinational.
//   instr  in   32-bit instruction word
//   imm    out  XLEN immediate, sign-extended from instr[31]; 0 for unknown opcodes
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  imm_fmt_t fmt;

  always_comb begin
    fmt = imm_fmt(instr[6:0]);
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
      IMM_S:   imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      IMM_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage between fetch and execute.
// Holds one instruction, stalls on RAW hazards against a pending-write
// scoreboard, strobes the register-file reads, captures the read data and
// presents a decoded bundle to execute over valid/ready.
//   clk, rst            clock, synchronous active-high reset
//   if_*                fetch handshake, instruction word and pc
//   rf_read_*           register-file read strobes/addresses, data one cycle later
//   wb_valid, wb_rd     writeback commit; clears the scoreboard bit
//   flush               kill the held instruction
//   ex_*                decoded bundle and handshake to execute
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [31:0]          if_instr,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 rf_read_enable1,
  output logic                 rf_read_enable2,
  output logic [ADDR_SIZE-1:0] rf_read_addr1,
  output logic [ADDR_SIZE-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]      rf_read_data1,
  input  logic [XLEN-1:0]      rf_read_data2,
  input  logic                 wb_valid,
  input  logic [ADDR_SIZE-1:0] wb_rd,
  input  logic                 flush,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [ADDR_SIZE-1:0] ex_rd,
  output logic [6:0]           ex_opcode,
  output logic [2:0]           ex_funct3,
  output logic                 ex_funct7_b5,
  output logic                 ex_illegal
);

  decode_state_t state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [31:0]          sb_q, sb_d;
  logic [XLEN-1:0]      ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]      ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0]      ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0]      ex_imm_q, ex_imm_d;
  logic [ADDR_SIZE-1:0] ex_rd_q, ex_rd_d;
  logic [6:0]           ex_opc_q, ex_opc_d;
  logic [2:0]           ex_f3_q, ex_f3_d;
  logic                 ex_f7b5_q, ex_f7b5_d;
  logic                 ex_ill_q, ex_ill_d;

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic            legal, use1, use2, wr, hazard;
  logic [XLEN-1:0] imm;

  assign opc = instr_q[6:0];
  assign rd  = instr_q[11:7];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  // Illegal opcodes read nothing and write nothing, so they never stall.
  assign legal  = is_legal(opc);
  assign use1   = legal && uses_rs1(opc);
  assign use2   = legal && uses_rs2(opc);
  assign wr     = legal && writes_rd(opc);
  assign hazard = (use1 && (rs1 != 5'd0) && sb_q[rs1]) ||
                  (use2 && (rs2 != 5'd0) && sb_q[rs2]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr_q),
    .imm   (imm)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    sb_d      = sb_q;
    ex_pc_d   = ex_pc_q;
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_imm_d  = ex_imm_q;
    ex_rd_d   = ex_rd_q;
    ex_opc_d  = ex_opc_q;
    ex_f3_d   = ex_f3_q;
    ex_f7b5_d = ex_f7b5_q;
    ex_ill_d  = ex_ill_q;
    if_ready        = 1'b0;
    ex_valid        = 1'b0;
    rf_read_enable1 = 1'b0;
    rf_read_enable2 = 1'b0;
    rf_read_addr1   = '0;
    rf_read_addr2   = '0;

    // Writebacks to indices above 31 are not tracked and must not alias.
    if (wb_valid && ((wb_rd >> 5) == '0)) sb_d[wb_rd[4:0]] = 1'b0;

    if (rst) begin
      state_d = S_EMPTY;
    end else if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if_ready = 1'b1;
          if (if_valid) begin
            instr_d = if_instr;
            pc_d    = if_pc;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (!hazard) begin
            rf_read_enable1 = legal;
            rf_read_enable2 = legal;
            rf_read_addr1   = use1 ? ADDR_SIZE'(rs1) : '0;
            rf_read_addr2   = use2 ? ADDR_SIZE'(rs2) : '0;
            state_d         = S_READ;
          end
        end
        S_READ: begin
          ex_pc_d   = pc_q;
          ex_rs1_d  = use1 ? rf_read_data1 : '0;
          ex_rs2_d  = use2 ? rf_read_data2 : '0;
          ex_imm_d  = imm;
          ex_rd_d   = wr ? ADDR_SIZE'(rd) : '0;
          ex_opc_d  = opc;
          ex_f3_d   = instr_q[14:12];
          ex_f7b5_d = instr_q[30];
          ex_ill_d  = !legal;
          state_d   = S_ISSUE;
        end
        S_ISSUE: begin
          ex_valid = 1'b1;
          if (ex_ready) begin
            // Applied after the writeback clear so a same-index set wins.
            if (ex_rd_q != '0) sb_d[ex_rd_q[4:0]] = 1'b1;
            state_d = S_EMPTY;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      instr_q   <= '0;
      pc_q      <= '0;
      sb_q      <= '0;
      ex_pc_q   <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_imm_q  <= '0;
      ex_rd_q   <= '0;
      ex_opc_q  <= '0;
      ex_f3_q   <= '0;
      ex_f7b5_q <= 1'b0;
      ex_ill_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      sb_q      <= sb_d;
      ex_pc_q   <= ex_pc_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_imm_q  <= ex_imm_d;
      ex_rd_q   <= ex_rd_d;
      ex_opc_q  <= ex_opc_d;
      ex_f3_q   <= ex_f3_d;
      ex_f7b5_q <= ex_f7b5_d;
      ex_ill_q  <= ex_ill_d;
    end
  end

  assign ex_pc        = ex_pc_q;
  assign ex_rs1_data  = ex_rs1_q;
  assign ex_rs2_data  = ex_rs2_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rd        = ex_rd_q;
  assign ex_opcode    = ex_opc_q;
  assign ex_funct3    = ex_f3_q;
  assign ex_funct7_b5 = ex_f7b5_q;
  assign ex_illegal   = ex_ill_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage placed between fetch and execute. It latches one fetched instruction, extracts the register indices, and stalls on RAW hazards using a pending-write scoreboard. Once clear, it issues the source reads to the register file and collects the read data one cycle later. It then hands a decoded bundle with a sign-extended immediate to execute over a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, datapath width
- ADDR_SIZE, 6, register-file address width; indices are zero-extended from 5 bits

Ports:
- clk  in  1  clock; everything samples on the rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  decode accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction address
- rf_read_enable1 / rf_read_enable2  out  1  register-file read strobes
- rf_read_addr1 / rf_read_addr2  out  ADDR_SIZE  source indices
- rf_read_data1 / rf_read_data2  in  XLEN  read data, valid the cycle after the strobe
- wb_valid  in  1  writeback commits a register write this cycle
- wb_rd  in  ADDR_SIZE  destination being written
- flush  in  1  kill the instruction held in decode
- ex_valid  out  1  bundle valid
- ex_ready  in  1  execute accepts the bundle
- ex_pc  out  XLEN  forwarded address
- ex_rs1_data / ex_rs2_data  out  XLEN  operands; zero when the source is unused
- ex_imm  out  XLEN  sign-extended immediate
- ex_rd  out  ADDR_SIZE  destination, or 0 if none
- ex_opcode  out  7, ex_funct3  out  3, ex_funct7_b5  out  1  decode fields
- ex_illegal  out  1  unrecognised opcode

## Operation
- FSM states: S_EMPTY, S_CHECK, S_READ, S_ISSUE.
- S_EMPTY:
  - if_ready=1.
  - if_valid && !flush latches instr/pc and moves to S_CHECK.
- S_CHECK:
  - Source use:
    - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
    - rs2 is used by BRANCH, STORE, OP.
  - Stall in S_CHECK while any used, nonzero source has its scoreboard bit set.
  - When clear, assert both rf_read_enable1 and rf_read_enable2 with the addresses for one cycle, then move to S_READ.
  - Unused-source addresses are driven to 0.
- S_READ:
  - Capture rf_read_data into ex_rs*_data.
  - Replace unused sources with 0.
  - Move to S_ISSUE.
- S_ISSUE:
  - ex_valid=1.
  - On ex_ready, set the scoreboard bit for ex_rd when ex_rd≠0, then move to S_EMPTY.
- Destination: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP write rd. All others give ex_rd=0.
- Immediate formats:
  - I for JALR, LOAD, OP-IMM.
  - S for STORE.
  - B for BRANCH.
  - U for LUI, AUIPC.
  - J for JAL.
  - All are sign-extended from instr[31]. Unknown opcode gives ex_imm=0.
- Illegal opcode: ex_illegal=1, no source reads (no stall), ex_rd=0. The instruction still issues.
- Scoreboard:
  - 32 bits; bit 0 is always 0.
  - wb_valid clears bit wb_rd at the clock edge.
  - The hazard check always uses the registered bits, so a source cleared by writeback in cycle N is read no earlier than N+1 and sees the new value.
  - Simultaneous set (issue) and clear (wb) of the same index: set wins.
- flush:
  - From any state, move to S_EMPTY next cycle.
  - ex_valid drops, no scoreboard set, if_ready=0 that cycle.
  - flush beats ex_ready in the same cycle.
  - Scoreboard entries of already-issued instructions are untouched.

## Timing
- Reset values: state S_EMPTY, scoreboard 0, all ex_* and rf_* outputs 0. if_ready=0 during rst.
- Reset mid-operation abandons the held instruction; nothing is issued.
- Minimum latency from acceptance to ex_valid is 3 cycles (S_CHECK, S_READ, S_ISSUE), i.e. one instruction every 4 cycles with no stalls.
- ex_* outputs hold stable while ex_valid && !ex_ready.
- rf_read_enable* is high for exactly one cycle per instruction.

## Structure
- Shared package riscv_pkg:
  - opcode localparams (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011)
  - decode_state_t enum
  - imm_fmt_t enum (I/S/B/U/J/NONE)
- Sub-module imm_gen: purely combinational, instr → imm_fmt_t → XLEN immediate. Instantiated once.
- The scoreboard and FSM stay in decode_stage.

## Test plan
- Reset, then `addi x5,x0,-1` (0xFFF00293): S_EMPTY→CHECK→READ→ISSUE; ex_imm=0xFFFFFFFF, ex_rd=5, ex_rs1_data=0; scoreboard[5]=1 after ex_ready.
- Issue `addi x5`, then `add x6,x5,x5` (0x00528333): decode stalls in S_CHECK; wb_valid, wb_rd=5 in cycle N; reads are strobed in N+1; ex_rs1_data = ex_rs2_data = value written.
- `sw x2,-4(x1)` (0xFE20AE23): ex_imm=0xFFFFFFFC, ex_rd=0, both sources read, no scoreboard set.
- Hold ex_ready=0 for 5 cycles in S_ISSUE: all ex_* are stable; if_ready=0; issue completes on the first ex_ready.
- flush together with ex_ready in S_ISSUE: no issue, scoreboard unchanged, S_EMPTY next cycle.
- Same-cycle issue of rd=7 and wb_rd=7: scoreboard[7]=1 afterwards. Opcode 0x7F gives ex_illegal=1 and no rf_read_enable.
